farm_sensor_ctrl: RTL

FARM_SENSOR_CTRL -- requirements
Module: farm_sensor_ctrl

---
 rtl/farm_pkg.sv | 24 ++
 rtl/sensor_debounce.sv | 50 +++++
 rtl/farm_sensor_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/farm_pkg.sv
// Shared light codes, FSM state type and light-code helpers for the farm-road sensor controller.
package farm_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW = 2'd1;
  localparam logic [1:0] LIGHT_RED    = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SERVE = 2'd2,
    ST_STUCK = 2'd3
  } farm_state_e;

  // Code 3 has no meaning on the light bus; fold it onto Red.
  function automatic logic [1:0] norm_light(input logic [1:0] code);
    return (code == 2'd3) ? LIGHT_RED : code;
  endfunction

  function automatic logic is_green(input logic [1:0] code);
    return norm_light(code) == LIGHT_GREEN;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for the raw loop level.
module sensor_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic loop_raw,
  output logic loop_db
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             db_q, db_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The count only advances while the synchronized level disagrees with loop_db;
  // any agreeing cycle (a glitch ending) drops it back to zero.
  always_comb begin
    sync1_d = loop_raw;
    sync2_d = sync1_q;
    cnt_d   = '0;
    db_d    = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign loop_db = db_q;

endmodule

// File: rtl/farm_sensor_ctrl.sv
// Farm-road vehicle queue estimator and request generator for the traffic controller.
// Optional stuck-high loop detection is built when FARM_STUCK_DET_EN is defined.
module farm_sensor_ctrl
  import farm_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int MAX_Q        = 15,
  parameter int STUCK_CYCLES = 63
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        loop_raw,
  input  logic [1:0]  f_s,
  output logic        farm_sensor,
  output logic [3:0]  veh_count,
  output logic        stuck,
  output farm_state_e dbg_state
);

  if (MAX_Q < 1 || MAX_Q > 15) begin : g_bad_max_q
    $error("farm_sensor_ctrl: MAX_Q must be 1..15");
  end
  if (DEB_CYCLES < 1 || STUCK_CYCLES < 1) begin : g_bad_cycles
    $error("farm_sensor_ctrl: DEB_CYCLES and STUCK_CYCLES must be >= 1");
  end

  localparam logic [3:0] MAX_V = 4'(MAX_Q);

  logic        loop_db;
  logic        db_prev_q, db_prev_d;
  logic        db_rise, db_fall;
  logic        green;
  logic        stuck_hit;
  farm_state_e state_q, state_d;
  logic [3:0]  veh_q, veh_d;

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .loop_raw (loop_raw),
    .loop_db  (loop_db)
  );

  assign db_prev_d = loop_db;
  assign db_rise   = loop_db & ~db_prev_q;
  assign db_fall   = ~loop_db & db_prev_q;
  assign green     = is_green(f_s);

`ifdef FARM_STUCK_DET_EN
  localparam int STK_W = $clog2(STUCK_CYCLES + 1);

  logic [STK_W-1:0] stk_cnt_q, stk_cnt_d;

  always_comb begin
    stk_cnt_d = '0;
    if (loop_db) begin
      stk_cnt_d = (stk_cnt_q == STK_W'(STUCK_CYCLES)) ? stk_cnt_q : stk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_cnt_q <= '0;
    end else begin
      stk_cnt_q <= stk_cnt_d;
    end
  end

  assign stuck_hit = loop_db && (stk_cnt_q == STK_W'(STUCK_CYCLES));
  assign stuck     = (state_q == ST_STUCK);
`else
  assign stuck_hit = 1'b0;
  assign stuck     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      veh_q     <= 4'd0;
      db_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      veh_q     <= veh_d;
      db_prev_q <= db_prev_d;
    end
  end

  // Leaving Green reloads the count from the current loop level and wins over
  // any loop edge seen in the same cycle.
  always_comb begin
    state_d = state_q;
    veh_d   = veh_q;
    case (state_q)
      ST_IDLE: begin
        if (db_rise) begin
          veh_d   = 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (db_rise && veh_q != MAX_V) begin
          veh_d = veh_q + 4'd1;
        end
        if (green) begin
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (!green) begin
          veh_d   = loop_db ? 4'd1 : 4'd0;
          state_d = loop_db ? ST_WAIT : ST_IDLE;
        end else if (db_fall && veh_q != 4'd0) begin
          veh_d = veh_q - 4'd1;
        end
      end
      ST_STUCK: begin
        if (db_fall) begin
          veh_d   = 4'd0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        veh_d   = 4'd0;
        state_d = ST_IDLE;
      end
    endcase
    if (stuck_hit && state_q != ST_STUCK) begin
      state_d = ST_STUCK;
    end
  end

  always_comb begin
    veh_count   = veh_q;
    farm_sensor = (veh_q != 4'd0) | stuck;
    dbg_state   = state_q;
  end

endmodule
